// File: rtl/immediate_decoder_pkg.sv
// immediate_decoder_pkg: immediate types, RV32I opcode constants and opcode classification
package immediate_decoder_pkg;
  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_type_e;
  typedef struct packed {
    logic      has_imm;
    logic      legal;
    imm_type_e imm_type;
  } imm_class_t;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  function automatic imm_class_t imm_class(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC: imm_class = '{1'b1, 1'b1, IMM_U};
      OPC_JAL: imm_class = '{1'b1, 1'b1, IMM_J};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: imm_class = '{1'b1, 1'b1, IMM_I};
      OPC_BRANCH: imm_class = '{1'b1, 1'b1, IMM_B};
      OPC_STORE: imm_class = '{1'b1, 1'b1, IMM_S};
      OPC_OP: imm_class = '{1'b0, 1'b1, IMM_I};
      default: imm_class = '{1'b0, 1'b0, IMM_I};
    endcase
  endfunction
endpackage

// File: rtl/immediate_decoder.sv
// immediate_decoder: sign-extended RV32I immediate extraction for a given immediate type
module immediate_decoder
  import immediate_decoder_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);
  always_comb
    imm = imm_type == IMM_S ? {{21{instr[31]}}, instr[30:25], instr[11:7]} :
          imm_type == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_type == IMM_U ? {instr[31:12], 12'b0} :
          imm_type == IMM_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                              {{21{instr[31]}}, instr[30:20]};
endmodule

// File: rtl/imm_decode_arbiter.sv
// imm_decode_arbiter: round-robin sharing of one immediate_decoder with a 1-entry response register.
// Optional opcode legality checking is enabled by defining IMM_DECODE_ARB_ILLEGAL_EN.
module imm_decode_arbiter
  import immediate_decoder_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][31:0]        req_instr,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [TAG_W-1:0]                rsp_tag,
  output logic [31:0]                     rsp_imm,
  output logic [2:0]                      rsp_imm_type,
  output logic                            rsp_has_imm,
  output logic                            rsp_illegal
);
  logic [ID_W-1:0] ptr, g, ptr_nxt;
  logic [ID_W:0] idx;
  logic found, accept, hs, illegal, has_imm;
  logic [31:0] instr_g, dec_imm, imm_val;
  imm_class_t cls;
  // First valid requester at or after ptr, wrapping
  always_comb begin
    g = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      idx = idx >= (ID_W+1)'(NUM_REQ) ? idx - (ID_W+1)'(NUM_REQ) : idx;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        g = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end
  assign accept = !rsp_valid || rsp_ready;
  assign hs = found && accept;
  assign req_ready = hs ? {{(NUM_REQ-1){1'b0}}, 1'b1} << g : '0;
  assign ptr_nxt = g == ID_W'(NUM_REQ-1) ? '0 : g + 1'b1;
  assign instr_g = req_instr[g];
  assign cls = imm_class(instr_g[6:0]);
  immediate_decoder u_dec (
    .instr    (instr_g),
    .imm_type (cls.imm_type),
    .imm      (dec_imm)
  );
`ifdef IMM_DECODE_ARB_ILLEGAL_EN
  assign illegal = !cls.legal || instr_g[1:0] != 2'b11;
`else
  assign illegal = 1'b0;
`endif
  assign has_imm = cls.has_imm && cls.legal && !illegal;
  assign imm_val = has_imm ? dec_imm : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_tag <= '0;
      rsp_imm <= '0;
      rsp_imm_type <= '0;
      rsp_has_imm <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (hs) begin
      ptr <= ptr_nxt;
      rsp_valid <= 1'b1;
      rsp_id <= g;
      rsp_tag <= req_tag[g];
      rsp_imm <= imm_val;
      rsp_imm_type <= cls.imm_type;
      rsp_has_imm <= has_imm;
      rsp_illegal <= illegal;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imm_decode_arbiter.sv
// tb_imm_decode_arbiter: scoreboard bench with directed spec cases and random traffic
module tb_imm_decode_arbiter;
  import immediate_decoder_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_valid = '0, req_ready;
  logic [1:0][31:0] req_instr = '0;
  logic [1:0][3:0] req_tag = '0;
  logic rsp_valid, rsp_has_imm, rsp_illegal;
  logic [0:0] rsp_id;
  logic [3:0] rsp_tag;
  logic [31:0] rsp_imm;
  logic [2:0] rsp_imm_type;
  int errors = 0, checks = 0;
  typedef struct {
    logic [0:0] id;
    logic [3:0] tag;
    logic [31:0] imm;
    logic [2:0] ty;
    logic has;
    logic ill;
  } exp_t;
  exp_t q[$];
  int mptr = 0;
  bit held = 0;
  always #5 clk = ~clk;
  imm_decode_arbiter #(.NUM_REQ(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_imm(rsp_imm), .rsp_imm_type(rsp_imm_type),
    .rsp_has_imm(rsp_has_imm), .rsp_illegal(rsp_illegal)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: immediates built by arithmetic shifts and masks of the whole word
  function automatic exp_t model(input logic [31:0] x, input int id, input logic [3:0] tag);
    exp_t e;
    logic [31:0] sx;
    bit legal;
    sx = 32'($signed(x) >>> 20);
    e.id = 1'(id);
    e.tag = tag;
    e.ty = IMM_I;
    e.has = 1;
    e.imm = 0;
    legal = 1;
    case (x[6:0])
      7'b0110111, 7'b0010111: begin e.ty = IMM_U; e.imm = x & 32'hFFFFF000; end
      7'b1101111: begin
        e.ty = IMM_J;
        e.imm = (32'($signed(x) >>> 11) & 32'hFFF00000) | (x & 32'h000FF000)
              | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: e.imm = sx;
      7'b1100011: begin
        e.ty = IMM_B;
        e.imm = (32'($signed(x) >>> 19) & 32'hFFFFF000) | (32'(x[7]) << 11)
              | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      end
      7'b0100011: begin e.ty = IMM_S; e.imm = (sx & ~32'h1F) | 32'(x[11:7]); end
      7'b0110011: e.has = 0;
      default: begin e.has = 0; legal = 0; end
    endcase
`ifdef IMM_DECODE_ARB_ILLEGAL_EN
    e.ill = !legal;
`else
    e.ill = 0;
`endif
    return e;
  endfunction
  // Predictor: expected grant from the RR pointer, pushes the response it will produce
  always @(posedge clk) begin
    int gi;
    logic [1:0] er;
    #3;
    if (rst_n) begin
      gi = -1;
      for (int k = 0; k < 2; k++) if (gi < 0 && req_valid[(mptr + k) % 2]) gi = (mptr + k) % 2;
      er = ((!held || rsp_ready) && gi >= 0) ? 2'(1 << gi) : 2'b0;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (er != 0) begin
        q.push_back(model(req_instr[gi], gi, req_tag[gi]));
        mptr = (gi + 1) % 2;
        held = 1;
      end else if (rsp_ready) held = 0;
    end
  end
  // Monitor: compares the held response against the scoreboard head, retires on rsp_ready
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        e = q[0];
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_imm", rsp_imm, e.imm);
        chk("rsp_imm_type", 32'(rsp_imm_type), 32'(e.ty));
        chk("rsp_has_imm", 32'(rsp_has_imm), 32'(e.has));
        chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end
  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ta, input logic [3:0] tb, input logic r);
    @(posedge clk);
    #1;
    req_valid = v;
    req_instr[0] = a;
    req_instr[1] = b;
    req_tag[0] = ta;
    req_tag[1] = tb;
    rsp_ready = r;
  endtask
  task automatic rsp(input string nm, input logic [31:0] imm, input logic [2:0] ty,
                     input logic [0:0] id, input logic [3:0] tag, input logic has);
    #1;
    chk({nm, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, ".imm"}, rsp_imm, imm);
    chk({nm, ".type"}, 32'(rsp_imm_type), 32'(ty));
    chk({nm, ".id"}, 32'(rsp_id), 32'(id));
    chk({nm, ".tag"}, 32'(rsp_tag), 32'(tag));
    chk({nm, ".has_imm"}, 32'(rsp_has_imm), 32'(has));
  endtask
  localparam logic [31:0] ADDI = 32'hFFF00093, LUI = 32'h12345037, JAL = 32'hFFDFF06F;
  localparam logic [31:0] BEQ = 32'hFE000EE3, SW = 32'hFE002C23, ADD = 32'h002081B3;
  logic [6:0] opcs [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
                            7'b0001111, 7'b1110011, 7'b1100011, 7'b0100011, 7'b0110011, 7'b1111111};
  initial begin
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(2'b01, ADDI, 0, 4'd5, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 1);
    rsp("addi", 32'hFFFFFFFF, IMM_I, 0, 4'd5, 1);
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, LUI, JAL, 4'd1, 4'd2, 1);
      if (i > 0) begin
        if (i % 2 == 1) rsp("rr_jal", 32'hFFFFFFFC, IMM_J, 1, 4'd2, 1);
        else rsp("rr_lui", 32'h12345000, IMM_U, 0, 4'd1, 1);
      end
    end
    drive(2'b01, BEQ, 0, 4'd7, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, BEQ, LUI, 4'd7, 4'd3, 0);
      rsp("stall_beq", 32'hFFFFFFFC, IMM_B, 0, 4'd7, 1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    drive(2'b11, BEQ, LUI, 4'd7, 4'd3, 1);
    #1 chk("release_grant", 32'(req_ready), 32'b10);
    drive(2'b01, SW, 0, 4'd9, 0, 1);
    drive(2'b01, ADD, 0, 4'd10, 0, 1);
    rsp("sw", 32'hFFFFFFF8, IMM_S, 0, 4'd9, 1);
    drive(2'b01, 32'h0000007F, 0, 4'd11, 0, 1);
    rsp("add", 32'h0, IMM_I, 0, 4'd10, 0);
    drive(2'b00, 0, 0, 0, 0, 1);
    rsp("bad_opc", 32'h0, IMM_I, 0, 4'd11, 0);
`ifdef IMM_DECODE_ARB_ILLEGAL_EN
    chk("illegal", 32'(rsp_illegal), 32'd1);
`else
    chk("illegal", 32'(rsp_illegal), 32'd0);
`endif
    drive(2'b01, ADDI, 0, 4'd4, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_imm", rsp_imm, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    q.delete();
    mptr = 0;
    held = 0;
    @(negedge clk) rst_n = 1'b1;
    drive(2'b11, ADDI, LUI, 4'd1, 4'd2, 1);
    #1 chk("first_grant_after_rst", 32'(req_ready), 32'b01);
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom() >> 7, opcs[$urandom_range(0, 11)]};
      rb = ($urandom_range(0, 7) == 0) ? $urandom() : {$urandom() >> 7, opcs[$urandom_range(0, 11)]};
      drive(2'($urandom()), ra, rb, 4'($urandom()), 4'($urandom()), $urandom_range(0, 3) != 0);
    end
    drive(2'b00, 0, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 1);
    drive(2'b00, 0, 0, 0, 0, 1);
    #3 chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
